// File: rtl/clockworks_emitter_uart.sv
// Byte-wide 8N1 UART transmitter with a conditioned system reset.
// The raw button is synchronized and every reset source is stretched before sys_resetn releases.
module clockworks_emitter_uart #(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 1000000,
  parameter int RST_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_reset,
  output logic       sys_resetn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int DIV = clk_freq_hz / baud_rate;
  localparam int TW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int RW  = $clog2(RST_CYCLES + 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("clockworks_emitter_uart: clk_freq_hz/baud_rate must be at least 2");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
      $error("clockworks_emitter_uart: RST_CYCLES must be at least 1");
    end
  endgenerate

  // Reset conditioning
  logic          btn_meta_reg   = 1'b0;
  logic          btn_sync_reg   = 1'b0;
  logic [RW-1:0] stretch_cnt_reg = '0;
  logic          sys_resetn_reg = 1'b0;

  always_ff @(posedge clk) begin
    btn_meta_reg <= btn_reset;
    btn_sync_reg <= btn_meta_reg;
  end

  always_ff @(posedge clk) begin
    if (!resetn || btn_sync_reg) begin
      stretch_cnt_reg <= '0;
      sys_resetn_reg  <= 1'b0;
    end else if (!sys_resetn_reg) begin
      if (stretch_cnt_reg == RST_LAST) begin
        sys_resetn_reg <= 1'b1;
      end else begin
        stretch_cnt_reg <= stretch_cnt_reg + RW'(1);
      end
    end
  end

  // Transmitter: the start bit is driven directly on acceptance, so the
  // shift register only holds the data bits followed by the stop bit.
  typedef enum logic {IDLE, SEND} tx_state_t;

  tx_state_t     state_reg   = IDLE;
  logic [8:0]    shift_reg   = '1;
  logic [3:0]    bit_cnt_reg = '0;
  logic [TW-1:0] timer_reg   = '0;
  logic          tx_reg      = 1'b1;
  logic          ready_reg   = 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      shift_reg   <= '1;
      bit_cnt_reg <= '0;
      timer_reg   <= '0;
      tx_reg      <= 1'b1;
      ready_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
          if (i_valid) begin
            shift_reg   <= {1'b1, i_data};
            timer_reg   <= DIV_LAST;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b0;
            ready_reg   <= 1'b0;
            state_reg   <= SEND;
          end
        end
        SEND: begin
          if (timer_reg == '0) begin
            if (bit_cnt_reg == 4'd9) begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
              ready_reg <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b1, shift_reg[8:1]};
              timer_reg   <= DIV_LAST;
            end
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign sys_resetn = sys_resetn_reg;
  assign o_ready    = ready_reg;
  assign o_uart_tx  = tx_reg;

endmodule

// File: tb/tb_clockworks_emitter_uart.sv
// Directed self-checking bench for clockworks_emitter_uart: default DIV=100
// instance plus a 12 MHz / 115200 instance for the DIV=104 case.
module tb_clockworks_emitter_uart;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_reset;
  logic       sys_resetn;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_uart_tx;

  logic       btn_reset2;
  logic       sys_resetn2;
  logic [7:0] i_data2;
  logic       i_valid2;
  logic       o_ready2;
  logic       o_uart_tx2;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clockworks_emitter_uart u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_reset  (btn_reset),
    .sys_resetn (sys_resetn),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_uart_tx  (o_uart_tx)
  );

  clockworks_emitter_uart #(
    .clk_freq_hz (12000000),
    .baud_rate   (115200)
  ) u_dut2 (
    .clk        (clk),
    .resetn     (resetn),
    .btn_reset  (btn_reset2),
    .sys_resetn (sys_resetn2),
    .i_data     (i_data2),
    .i_valid    (i_valid2),
    .o_ready    (o_ready2),
    .o_uart_tx  (o_uart_tx2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until sys_resetn reads high, 0 on timeout.
  task automatic wait_sys_high(output int k);
    k = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (sys_resetn === 1'b1) begin
        k = n;
        break;
      end
    end
  endtask

  task automatic accept(input string tag, input logic [7:0] data);
    check({tag, "_ready_pre"}, o_ready, 1);
    i_data  = data;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check({tag, "_ready_drop"}, o_ready, 0);
  endtask

  // Called one edge after acceptance; exp_bits[i] is the i-th bit on the wire.
  // mode 1: one-cycle 0x55 pulse mid-frame; 2: hold 0x55 request from mid-frame;
  // 3: 3-cycle btn_reset pulse mid-frame.
  task automatic frame_check(input string tag, input logic [9:0] exp_bits, input int mode);
    int bad;
    int low_cnt;
    logic exp_bit;
    bad = 0;
    low_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      exp_bit = exp_bits[c / 100];
      if (o_uart_tx !== exp_bit) bad++;
      if (o_ready === 1'b0) low_cnt++;
      if ((mode == 1 || mode == 2) && c == 500) begin
        i_data  = 8'h55;
        i_valid = 1'b1;
      end
      if (mode == 1 && c == 501) i_valid = 1'b0;
      if (mode == 3 && c == 200) btn_reset = 1'b1;
      if (mode == 3 && c == 203) btn_reset = 1'b0;
      tick();
    end
    check({tag, "_bad_bit_samples"}, bad, 0);
    check({tag, "_ready_low_cycles"}, low_cnt, 1000);
    check({tag, "_end_ready"}, o_ready, 1);
    check({tag, "_end_tx"}, o_uart_tx, 1);
  endtask

  task automatic abort_test(input string tag, input logic [7:0] data, input logic tx_before);
    int bad;
    int k;
    accept(tag, data);
    repeat (349) tick();
    check({tag, "_tx_before_abort"}, o_uart_tx, tx_before);
    resetn = 1'b0;
    tick();
    check({tag, "_tx_after_abort"}, o_uart_tx, 1);
    check({tag, "_ready_after_abort"}, o_ready, 1);
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (o_uart_tx !== 1'b1 || o_ready !== 1'b1) bad++;
    end
    check({tag, "_no_resume"}, bad, 0);
  endtask

  initial begin
    int k;
    int bad;
    int first_low;
    int rise;
    int low2;
    int zeros2;
    int c;

    resetn     = 1'b0;
    btn_reset  = 1'b0;
    i_data     = 8'h00;
    i_valid    = 1'b0;
    btn_reset2 = 1'b0;
    i_data2    = 8'h00;
    i_valid2   = 1'b0;

    #1;
    check("powerup_tx", o_uart_tx, 1);
    check("powerup_sys_resetn", sys_resetn, 0);

    repeat (4) tick();
    check("reset_ready", o_ready, 1);
    check("reset_tx", o_uart_tx, 1);
    check("reset_sys_resetn", sys_resetn, 0);

    resetn = 1'b1;
    wait_sys_high(k);
    check("release_to_sys_high", k, 16);

    // Re-asserting during the stretch restarts the count.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (8) tick();
    check("stretch_mid_low", sys_resetn, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    wait_sys_high(k);
    check("restart_to_sys_high", k, 16);

    accept("f41", 8'h41);
    frame_check("f41", 10'h282, 0);

    accept("ign", 8'h41);
    frame_check("ign", 10'h282, 1);
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (o_uart_tx !== 1'b1 || o_ready !== 1'b1) bad++;
    end
    check("ign_idle_after", bad, 0);

    accept("hold", 8'h41);
    frame_check("hold", 10'h282, 2);
    tick();
    i_valid = 1'b0;
    check("hold_next_accepted", o_ready, 0);
    frame_check("f55", 10'h2AA, 0);

    accept("btn_tx", 8'h55);
    frame_check("btn_tx", 10'h2AA, 3);
    wait_sys_high(k);
    check("btn_tx_sys_recovers", (k != 0), 1);

    // Idle button pulse: 2-cycle sync latency, 3-cycle pulse, 16-cycle stretch.
    btn_reset = 1'b1;
    first_low = 0;
    rise = 0;
    bad = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 3) btn_reset = 1'b0;
      if (sys_resetn === 1'b0 && first_low == 0) first_low = n;
      if (first_low != 0 && sys_resetn === 1'b1 && rise == 0) rise = n;
      if (o_uart_tx !== 1'b1 || o_ready !== 1'b1) bad++;
    end
    check("btn_sys_low_edge", first_low, 3);
    check("btn_sys_high_edge", rise, 21);
    check("btn_tx_idle_untouched", bad, 0);

    abort_test("abort_ff", 8'hFF, 1'b1);
    abort_test("abort_00", 8'h00, 1'b0);

    // DIV = 104 instance
    check("div104_ready_pre", o_ready2, 1);
    i_data2  = 8'h41;
    i_valid2 = 1'b1;
    tick();
    i_valid2 = 1'b0;
    zeros2 = 0;
    for (c = 0; c < 2000 && o_ready2 === 1'b0; c++) begin
      if (c < 150 && o_uart_tx2 === 1'b0) zeros2++;
      tick();
    end
    low2 = c;
    check("div104_frame_cycles", low2, 1040);
    check("div104_start_bit_cycles", zeros2, 104);
    check("div104_end_tx", o_uart_tx2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/clockworks_emitter_uart.md
CLOCKWORKS_EMITTER_UART -- requirements
Module: clockworks_emitter_uart

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 100000000, the clk frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 1000000, the UART bit rate in bit/s.
REQ-003 SHALL have parameter RST_CYCLES, default 16, the minimum stretch of sys_resetn low after a reset source releases.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 btn_reset  input  1  raw board reset button, active-high, asynchronous to clk.
REQ-007 sys_resetn  output  1  conditioned system reset for downstream logic, active-low.
REQ-008 i_data  input  8  byte to transmit.
REQ-009 i_valid  input  1  transmit request; i_data is sampled on the accepting edge.
REQ-010 o_ready  output  1  high when the transmitter can accept a byte.
REQ-011 o_uart_tx  output  1  serial TX line, idle high.

Function
REQ-012 Bit period SHALL be DIV = clk_freq_hz/baud_rate clk cycles, integer division (100 with the defaults); DIV >= 2 SHALL be required.
REQ-013 btn_reset SHALL pass through a 2-flop synchronizer before use.
REQ-014 sys_resetn SHALL be low while resetn is low or the synchronized btn_reset is high.
REQ-015 After the last of these conditions releases, sys_resetn SHALL stay low for exactly RST_CYCLES further cycles, then go high.
REQ-016 A reset source re-asserting during the stretch SHALL restart the count.
REQ-017 The TX state machine SHALL have states IDLE and SEND.
REQ-018 IDLE: o_ready=1 and o_uart_tx=1.
REQ-019 In IDLE, i_valid=1 at an edge SHALL accept the byte: latch frame {1 stop, i_data[7:0], 0 start}, load the bit-timer with DIV-1, enter SEND.
REQ-020 o_ready SHALL be 0 from the cycle after acceptance until the frame completes.
REQ-021 SEND SHALL drive 10 bits LSB-first (start 0, d0..d7, stop 1), each exactly DIV cycles.
REQ-022 The start bit SHALL appear on o_uart_tx the cycle after acceptance.
REQ-023 After the stop bit's DIV cycles the machine SHALL return to IDLE with o_ready=1.
REQ-024 Consecutive frames SHALL have no extra idle cycles: the next byte is accepted in the first IDLE cycle, and its start bit follows immediately.
REQ-025 i_valid while o_ready=0 SHALL be ignored; the byte is not queued.
REQ-026 i_data changes after acceptance SHALL not affect the frame in flight.
REQ-027 Frame length SHALL be 10*DIV cycles.
REQ-028 The acceptance handshake itself SHALL be one cycle (valid && ready).
REQ-029 Bit-timer and bit-counter SHALL be wide enough for DIV-1 and 9 and SHALL never wrap mid-bit.
REQ-030 o_uart_tx SHALL be registered, with no combinational glitches.

Reset
REQ-031 On an edge with resetn=0: TX state IDLE, o_uart_tx=1, o_ready=1, timers cleared, stretch counter reloaded, sys_resetn=0.
REQ-032 resetn low mid-frame SHALL abort the frame: line high and o_ready=1 on the next edge, nothing resumes after release.
REQ-033 btn_reset SHALL affect only sys_resetn, never the transmitter.
REQ-034 At power-up (initial values) sys_resetn SHALL be 0 and o_uart_tx SHALL be 1.

Verification
REQ-035 i_data=0x41 with one cycle of i_valid from IDLE -> o_uart_tx sends 0,1,0,0,0,0,0,1,0,1, 100 cycles each starting the next cycle; o_ready low for exactly 1000 cycles.
REQ-036 Second byte 0x55 pulsed at cycle 500 of a frame -> ignored, line idles high after the first frame; held i_valid -> 0x55 frame starts right after the stop bit.
REQ-037 resetn low at cycle 350 of a 0xFF frame -> o_uart_tx=1 and o_ready=1 on the next edge, no further bit transitions.
REQ-038 btn_reset pulsed high 3 cycles -> sys_resetn low through synchronizer latency + pulse + 16 cycles, then high; TX line unaffected.
REQ-039 Override clk_freq_hz=12000000, baud_rate=115200 -> DIV=104, frame 1040 cycles.
REQ-040 After resetn release -> o_ready=1, o_uart_tx=1, sys_resetn high exactly 16 cycles after release (btn_reset low).
